hack_alu_mul_seq: RTL and testbench

- Multi-cycle 16-bit multiplier sequencer built around the combinational Hack ALU (16-bit x/y inputs, control bits zx nx zy ny f no, outputs out zr ng).
- Uses only the ALU's "x+y" function: the ALU is instantiated outside this block, and this block drives the ALU operands and control bits and reads back the ALU result.
- Runs a shift-and-add loop to produce the low 16 bits of a*b, presented with Hack-style zr/ng flags.
- Uses valid/ready handshakes on both the command side and the result side.

---
 rtl/hack_alu_mul_seq.sv | 105 ++++++++++
 tb/tb_hack_alu_mul_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hack_alu_mul_seq.sv
// Shift-and-add 16-bit multiplier sequencer that drives an external Hack ALU
// in x+y mode and returns the low half of a*b with Hack-style zr/ng flags.
module hack_alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product,
  output logic             zr,
  output logic             ng,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  input  logic [WIDTH-1:0] alu_out
);

  // state  | meaning
  // S_IDLE | waiting for a command, in_ready high
  // S_ADD  | acc <= acc + mc, clears the current multiplier bit
  // S_DBL  | mc <= mc + mc, shifts the multiplier right
  // S_DONE | result presented until out_ready
  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DBL, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mc;
  logic [WIDTH-1:0] mp;
  logic [WIDTH-1:0] mp_shr;

  assign mp_shr = mp >> 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      acc   <= '0;
      mc    <= '0;
      mp    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            acc <= '0;
            mc  <= a;
            mp  <= b;
            if (b == '0)    state <= S_DONE;
            else if (b[0])  state <= S_ADD;
            else            state <= S_DBL;
          end
        end
        S_ADD: begin
          acc   <= alu_out;
          mp[0] <= 1'b0;
          state <= (mp[WIDTH-1:1] == '0) ? S_DONE : S_DBL;
        end
        S_DBL: begin
          mc <= alu_out;
          mp <= mp_shr;
          if (mp_shr == '0)    state <= S_DONE;
          else if (mp_shr[0])  state <= S_ADD;
          else                 state <= S_DBL;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ALU is held at the constant-0 function whenever it is not adding.
  always_comb begin
    alu_x  = '0;
    alu_y  = '0;
    alu_zx = 1'b1;
    alu_nx = 1'b0;
    alu_zy = 1'b1;
    alu_ny = 1'b0;
    alu_f  = 1'b1;
    alu_no = 1'b0;
    if (state == S_ADD || state == S_DBL) begin
      alu_zx = 1'b0;
      alu_zy = 1'b0;
      alu_x  = (state == S_ADD) ? acc : mc;
      alu_y  = mc;
    end
  end

  assign in_ready  = (state == S_IDLE) && !reset;
  assign out_valid = (state == S_DONE);
  assign product   = (state == S_DONE) ? acc : '0;
  assign zr        = (product == '0);
  assign ng        = product[WIDTH-1];

endmodule

// File: tb/tb_hack_alu_mul_seq.sv
// Scoreboard bench for hack_alu_mul_seq with a behavioural Hack ALU attached.
module tb_hack_alu_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        zr, ng;
  logic [15:0] alu_x, alu_y, alu_out;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;

  typedef struct {
    logic [15:0] prod;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hack_alu_mul_seq #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .zr(zr), .ng(ng), .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
    .alu_f(alu_f), .alu_no(alu_no), .alu_out(alu_out)
  );

  // Hack ALU reference
  logic [15:0] hx1, hx2, hy1, hy2, ho;
  always_comb begin
    hx1 = alu_zx ? 16'h0 : alu_x;
    hx2 = alu_nx ? ~hx1 : hx1;
    hy1 = alu_zy ? 16'h0 : alu_y;
    hy2 = alu_ny ? ~hy1 : hy1;
    ho  = alu_f ? (hx2 + hy2) : (hx2 & hy2);
    alu_out = alu_no ? ~ho : ho;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_lat(input logic [15:0] bv);
    int pc = 0;
    int msb = 0;
    for (int i = 0; i < 16; i++) begin
      if (bv[i]) begin
        pc++;
        msb = i;
      end
    end
    return (bv == 16'h0) ? 0 : pc + msb;
  endfunction

  function automatic logic [5:0] ctrl();
    return {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
  endfunction

  task automatic send(input logic [15:0] av, input logic [15:0] bv);
    exp_t e;
    int   n = 0;
    logic [31:0] full;
    @(negedge clk);
    a = av;
    b = bv;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", 1, 0);
    @(posedge clk);
    full   = av * bv;
    e.prod = full[15:0];
    e.lat  = model_lat(bv);
    exp_q.push_back(e);
    #1;
    in_valid = 1'b0;
    a = 16'hDEAD;
    b = 16'hBEEF;
  endtask

  // hold: cycles to keep out_ready low once the result appears
  task automatic wait_result(input int hold);
    exp_t e;
    int   cnt = 0;
    int   ctrl_err = 0;
    int   rdy_err = 0;
    int   stab_err = 0;
    logic [15:0] p0;
    logic z0, n0;
    out_ready = (hold == 0);
    while (cnt < 100) begin
      cnt++;
      if (out_valid) break;
      if (ctrl() != 6'b000010) ctrl_err++;
      if (in_ready) rdy_err++;
      @(posedge clk);
      #1;
    end
    if (!out_valid) begin
      check("result_timeout", 1, 0);
      return;
    end
    if (exp_q.size() == 0) begin
      check("unexpected_result", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check("latency", cnt, e.lat + 1);
    check("product", product, e.prod);
    check("zr", zr, e.prod == 16'h0);
    check("ng", ng, e.prod[15]);
    check("busy_ctrl_errs", ctrl_err, 0);
    check("busy_in_ready_errs", rdy_err, 0);
    check("done_ctrl", {ctrl(), alu_x, alu_y}, {6'b101010, 32'h0});
    if (hold > 0) begin
      p0 = product; z0 = zr; n0 = ng;
      a = 16'h0007; b = 16'h0007; in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        if (!out_valid || product !== p0 || zr !== z0 || ng !== n0) stab_err++;
        if (in_ready) stab_err++;
      end
      in_valid = 1'b0;
      check("backpressure_stable_errs", stab_err, 0);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("out_valid_drop", out_valid, 0);
    check("idle_in_ready", in_ready, 1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_flags", {product, zr, ng}, {16'h0, 1'b1, 1'b0});
    check("rst_ctrl", ctrl(), 6'b101010);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    send(16'h0003, 16'h0005); wait_result(0);
    check("p_3x5", exp_q.size(), 0);
    send(16'hAAAA, 16'hF0F0); wait_result(0);
    send(16'hFFFF, 16'hFFFF); wait_result(0);
    send(16'h1234, 16'h0000); wait_result(0);
    send(16'h8000, 16'h0002); wait_result(0);
    send(16'h4000, 16'h0002); wait_result(0);
    send(16'h0102, 16'h0304); wait_result(10);
    send(16'h0005, 16'h0007); wait_result(0);
    for (int i = 0; i < 6; i++) begin
      send(16'($urandom), 16'($urandom));
      wait_result(i % 2);
    end

    // asynchronous reset mid-operation
    send(16'hFFFF, 16'hFFFF);
    repeat (7) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_flags", {product, zr, ng}, {16'h0, 1'b1, 1'b0});
    check("midrst_alu", {ctrl(), alu_x, alu_y}, {6'b101010, 32'h0});
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    send(16'h0002, 16'h0003); wait_result(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
